// File: rtl/fp16_mul_round.sv
// Normalize/round/pack stage of the binary16 multiplier: 22-bit significand product in, IEEE result + flags out.
// Two registered stages with valid/ready; in_ready is combinational from out_ready.
module fp16_mul_round #(
  parameter int BIAS = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [21:0] in_prod,
  input  logic [6:0]  in_exp,
  input  logic        in_sign,
  input  logic [1:0]  in_class,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_flags
);

  if (BIAS < 1) begin : g_bias_check
    $error("BIAS must be positive");
  end

  localparam logic [1:0] CLS_FINITE = 2'b00;
  localparam logic [1:0] CLS_ZERO   = 2'b01;
  localparam logic [1:0] CLS_INF    = 2'b10;

  logic        s1_valid;
  logic [21:0] s1_m;
  logic [7:0]  s1_e;
  logic        s1_sticky;
  logic        s1_tiny;
  logic        s1_sign;
  logic [1:0]  s1_class;
  logic        s1_zero;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !reset;

  // Stage 1: normalize, then denormalize into the subnormal range when E <= 0.
  logic [4:0]  lzc;
  logic [21:0] norm;
  logic [7:0]  e_norm;
  logic [7:0]  sh_full;
  logic [4:0]  sh;
  logic [44:0] shifted;
  logic        tiny_n;

  always_comb begin
    lzc = 5'd22;
    for (int i = 0; i < 22; i++) begin
      if (in_prod[i]) lzc = 5'(21 - i);
    end
    norm    = in_prod << lzc;
    e_norm  = {in_exp[6], in_exp} + 8'd1 - {3'b000, lzc};
    tiny_n  = $signed(e_norm) <= 8'sd0;
    sh_full = 8'd1 - e_norm;
    sh      = 5'd0;
    if (tiny_n) sh = (sh_full > 8'd23) ? 5'd23 : sh_full[4:0];
    // Low 23 bits collect everything shifted past the bottom of m.
    shifted = {norm, 23'd0} >> sh;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_m      <= '0;
      s1_e      <= '0;
      s1_sticky <= 1'b0;
      s1_tiny   <= 1'b0;
      s1_sign   <= 1'b0;
      s1_class  <= CLS_FINITE;
      s1_zero   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_m      <= shifted[44:23];
        s1_e      <= tiny_n ? 8'd0 : e_norm;
        s1_sticky <= |shifted[22:0];
        s1_tiny   <= tiny_n;
        s1_sign   <= in_sign;
        s1_class  <= in_class;
        s1_zero   <= (in_prod == 22'd0);
      end
    end
  end

  // Stage 2: round to nearest even and pack.
  logic        g;
  logic        s;
  logic        inc;
  logic [4:0]  exp_f;
  logic [15:0] sum;
  logic        ovf;
  logic        inexact;
  logic [15:0] res_n;
  logic [2:0]  flags_n;

  always_comb begin
    g       = s1_m[10];
    s       = (|s1_m[9:0]) || s1_sticky;
    inc     = g && (s || s1_m[11]);
    exp_f   = s1_m[21] ? s1_e[4:0] : 5'd0;
    // A carry out of the fraction bumps the exponent field directly.
    sum     = {1'b0, exp_f, s1_m[20:11]} + {15'd0, inc};
    ovf     = (sum[15:10] >= 6'd31) || ($signed(s1_e) >= 8'sd31);
    inexact = g || s;
    res_n   = {s1_sign, sum[14:0]};
    flags_n = {1'b0, s1_tiny && inexact, inexact};
    if (ovf) begin
      res_n   = {s1_sign, 15'h7C00};
      flags_n = 3'b101;
    end
    if (s1_class == CLS_ZERO || (s1_class == CLS_FINITE && s1_zero)) begin
      res_n   = {s1_sign, 15'h0000};
      flags_n = 3'b000;
    end else if (s1_class == CLS_INF) begin
      res_n   = {s1_sign, 15'h7C00};
      flags_n = 3'b000;
    end else if (s1_class == 2'b11) begin
      res_n   = 16'h7E00;
      flags_n = 3'b000;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_flags  <= 3'b000;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_n;
        out_flags  <= flags_n;
      end
    end
  end

endmodule

// File: tb/tb_fp16_mul_round.sv
// Directed bench for fp16_mul_round: hand-computed vectors, streaming backpressure, mid-stream reset.
module tb_fp16_mul_round;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_prod;
  logic [6:0]  in_exp;
  logic        in_sign;
  logic [1:0]  in_class;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;

  int n_cmp = 0;
  int n_bad = 0;

  fp16_mul_round #(.BIAS(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_exp     (in_exp),
    .in_sign    (in_sign),
    .in_class   (in_class),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated beat: accepted at the first posedge, visible after the second.
  task automatic run_one(input string tag, input logic [21:0] p, input logic [6:0] e,
                         input logic sg, input logic [1:0] c,
                         input logic [15:0] r, input logic [2:0] f);
    @(negedge clock);
    in_valid = 1'b1; out_ready = 1'b1;
    in_prod = p; in_exp = e; in_sign = sg; in_class = c;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_prod  = 22'h3FFFFF;
    check({tag, "_not_early"}, 32'(out_valid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(out_result), 32'(r));
    check({tag, "_flags"}, 32'(out_flags), 32'(f));
  endtask

  bit [3:0]    pat = 4'b1001;
  int          sent, recv, occ;
  logic        acc, emit, held_vld;
  logic [15:0] held_res;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_prod = '0; in_exp = '0; in_sign = 1'b0; in_class = 2'b00;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'h0000);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_one("one_x_one",   22'h100000, 7'd15,  1'b0, 2'b00, 16'h3C00, 3'b000);
    run_one("1p5_x_1p5",   22'h240000, 7'd15,  1'b0, 2'b00, 16'h4080, 3'b000);
    run_one("tie_odd",     22'h200C00, 7'd15,  1'b0, 2'b00, 16'h4002, 3'b001);
    run_one("tie_even",    22'h200400, 7'd15,  1'b0, 2'b00, 16'h4000, 3'b001);
    run_one("ovf_big",     22'h3FF001, 7'd30,  1'b1, 2'b00, 16'hFC00, 3'b101);
    run_one("ovf_round",   22'h3FFC00, 7'd29,  1'b0, 2'b00, 16'h7C00, 3'b101);
    run_one("mant_carry",  22'h3FFC00, 7'd15,  1'b0, 2'b00, 16'h4400, 3'b001);
    run_one("sub_exact",   22'h100000, 7'h77,  1'b0, 2'b00, 16'h0001, 3'b000);
    run_one("sub_half",    22'h100000, 7'h76,  1'b0, 2'b00, 16'h0000, 3'b011);
    run_one("sub_to_norm", 22'h1FFC00, 7'd0,   1'b0, 2'b00, 16'h0400, 3'b011);
    run_one("nan",         22'h123456, 7'd20,  1'b1, 2'b11, 16'h7E00, 3'b000);
    run_one("inf_neg",     22'h100000, 7'd15,  1'b1, 2'b10, 16'hFC00, 3'b000);
    run_one("zero_class",  22'h100000, 7'd15,  1'b1, 2'b01, 16'h8000, 3'b000);
    run_one("zero_prod",   22'h000000, 7'd15,  1'b0, 2'b00, 16'h0000, 3'b000);

    // Stream 6 beats with out_ready cycling 1,0,0,1; expected result k is 0x3C00 + k*0x400.
    sent = 0; recv = 0; occ = 0; held_vld = 1'b0; held_res = '0;
    for (int cyc = 0; cyc < 100 && recv < 6; cyc++) begin
      @(negedge clock);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 6);
      in_prod   = 22'h100000;
      in_exp    = 7'(15 + sent);
      in_sign   = 1'b0;
      in_class  = 2'b00;
      #1;
      check("stream_in_ready", 32'(in_ready), 32'((occ == 2 && !out_ready) ? 0 : 1));
      if (held_vld) check("stall_hold", 32'(out_result), 32'(held_res));
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        check("stream_order", 32'(out_result), 32'(16'h3C00 + 16'(recv) * 16'h0400));
        check("stream_flags", 32'(out_flags), 32'd0);
        recv++;
      end
      held_vld = out_valid && !out_ready;
      held_res = out_result;
      @(posedge clock);
      if (acc) sent++;
      occ = occ + int'(acc) - int'(emit);
    end
    check("stream_sent", 32'(sent), 32'd6);
    check("stream_recv", 32'(recv), 32'd6);

    // Fill both stages with out_ready low, then reset mid-stream.
    @(negedge clock);
    in_valid = 1'b1; out_ready = 1'b0;
    in_prod = 22'h240000; in_exp = 7'd15;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("fill_valid", 32'(out_valid), 32'd1);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_result", 32'(out_result), 32'h0000);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("midrst_dropped", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
